// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared prescaled period counter (edge- or center-aligned) with
// per-channel double-buffered duty, per-channel polarity and a period-boundary strobe.
module pwm_multi #(
  parameter int unsigned CH         = 4,
  parameter int unsigned N          = 8,
  parameter int unsigned PRESC_BITS = 15,
  localparam int unsigned CHW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [PRESC_BITS-1:0] prescale,
  input  logic [N-1:0]          period,
  input  logic [CH-1:0]         polarity,
  input  logic                  wr_en,
  input  logic [CHW-1:0]        wr_ch,
  input  logic [N:0]            wr_duty,
  output logic [CH-1:0]         pwm_out,
  output logic                  period_tick
);

  localparam logic DirUp   = 1'b0;
  localparam logic DirDown = 1'b1;

  localparam logic [CHW:0] ChLim  = (CHW+1)'(CH);
  localparam logic [N-1:0] CntOne = N'(1);

  logic [PRESC_BITS-1:0] psc_q, psc_d;
  logic [N-1:0]          cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic [N-1:0]          per_act_q;
  logic [N:0]            shadow_q   [CH];
  logic [N:0]            duty_act_q [CH];
  logic [CH-1:0]         pwm_d;
  logic                  tick;
  logic                  boundary;
  logic                  load_act;

  assign tick     = enable && (psc_q == prescale);
  assign load_act = !enable || boundary;

  // psc past prescale (prescale lowered mid-count) rolls over at its maximum
  always_comb begin
    psc_d = psc_q + 1'b1;
    if (!enable || tick) begin
      psc_d = '0;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (!enable) begin
      cnt_d = '0;
      dir_d = DirUp;
    end else if (tick) begin
      if (per_act_q == '0) begin
        cnt_d    = '0;
        dir_d    = DirUp;
        boundary = 1'b1;
      end else if (!mode) begin
        if (cnt_q >= per_act_q) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (dir_q == DirUp && cnt_q < per_act_q) begin
        cnt_d = cnt_q + 1'b1;
      end else if (dir_q == DirUp && cnt_q == per_act_q) begin
        // With a top of 1 the turn-around point is also the period boundary
        if (per_act_q == CntOne) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = per_act_q - 1'b1;
          dir_d = DirDown;
        end
      end else begin
        // Counting down, or above the top after a switch into center mode
        dir_d = DirDown;
        if (cnt_q <= CntOne) begin
          cnt_d    = '0;
          dir_d    = DirUp;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < int'(CH); i++) begin
      pwm_d[i] = (enable && ({1'b0, cnt_q} < duty_act_q[i])) ^ polarity[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc_q       <= '0;
      cnt_q       <= '0;
      dir_q       <= DirUp;
      per_act_q   <= '0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
    end else begin
      psc_q       <= psc_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      pwm_out     <= pwm_d;
      period_tick <= boundary;
      if (load_act) begin
        per_act_q <= period;
      end
    end
  end

  // Active duty samples the pre-write shadow, so a write on a boundary lands one period later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q   <= '{default: '0};
      duty_act_q <= '{default: '0};
    end else begin
      if (load_act) begin
        duty_act_q <= shadow_q;
      end
      if (wr_en && ({1'b0, wr_ch} < ChLim)) begin
        shadow_q[wr_ch] <= wr_duty;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: expected outputs come from a closed-form period/phase
// model of the counter, pushed per clock and popped when the DUT output is sampled.
module tb_pwm_multi;

  localparam int unsigned CH = 3;
  localparam int unsigned N  = 8;
  localparam int unsigned PB = 15;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic            mode;
  logic [PB-1:0]   prescale;
  logic [N-1:0]    period;
  logic [CH-1:0]   polarity;
  logic            wr_en;
  logic [1:0]      wr_ch;
  logic [N:0]      wr_duty;
  logic [CH-1:0]   pwm_out;
  logic            period_tick;

  always #5 clk = ~clk;

  pwm_multi #(
    .CH         (CH),
    .N          (N),
    .PRESC_BITS (PB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .mode        (mode),
    .prescale    (prescale),
    .period      (period),
    .polarity    (polarity),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] sb_q[$];

  int         cfg_p, cfg_s, cfg_mode, chg_per, wr_at;
  logic [8:0] d_old [3];
  logic [8:0] d_new [3];
  logic [1:0] wr_ch_v;
  logic [8:0] wr_val;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {period_tick, pwm_out} after the j-th enabled clock edge
  function automatic logic [3:0] model(input int j);
    int t, l, ph, c, pidx, d;
    logic [3:0] r;
    t    = j / (cfg_s + 1);
    l    = (cfg_p == 0) ? 1 : (cfg_mode != 0 ? 2 * cfg_p : cfg_p + 1);
    ph   = t % l;
    c    = (cfg_p == 0) ? 0 : ((cfg_mode != 0 && ph > cfg_p) ? 2 * cfg_p - ph : ph);
    pidx = t / l;
    r    = '0;
    for (int ch = 0; ch < 3; ch++) begin
      d     = (pidx >= chg_per) ? int'(d_new[ch]) : int'(d_old[ch]);
      r[ch] = (c < d) ^ polarity[ch];
    end
    r[3] = ((j % (cfg_s + 1)) == cfg_s) && (((t + 1) % l) == 0);
    return r;
  endfunction

  task automatic sb_check(input string tag);
    logic [3:0] exp;
    exp = sb_q.pop_front();
    check_eq(tag, {28'd0, period_tick, pwm_out}, {28'd0, exp});
  endtask

  // Loads config with enable low (active registers track shadow/period immediately)
  task automatic setup(input int md, input int p, input int s, input logic [2:0] pol,
                       input logic [8:0] d0, input logic [8:0] d1, input logic [8:0] d2);
    enable   = 1'b0;
    mode     = md[0];
    period   = p[7:0];
    prescale = s[14:0];
    polarity = pol;
    cfg_mode = md;
    cfg_p    = p;
    cfg_s    = s;
    d_old[0] = d0; d_old[1] = d1; d_old[2] = d2;
    d_new    = d_old;
    chg_per  = 1 << 30;
    wr_at    = -1;
    for (int ch = 0; ch < 3; ch++) begin
      wr_en   = 1'b1;
      wr_ch   = ch[1:0];
      wr_duty = d_old[ch];
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.push_back({1'b0, pol});
    sb_check("idle_disabled");
  endtask

  task automatic run(input string tag, input int n);
    enable = 1'b1;
    for (int j = 0; j < n; j++) begin
      wr_en = (j == wr_at);
      if (j == wr_at) begin
        wr_ch   = wr_ch_v;
        wr_duty = wr_val;
      end
      @(posedge clk);
      #1 sb_q.push_back(model(j));
      @(negedge clk);
      sb_check(tag);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    mode     = 1'b0;
    prescale = '0;
    period   = '0;
    polarity = 3'b101;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_duty  = '0;
    #12;
    sb_q.push_back(4'b0000);
    sb_check("reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sb_q.push_back({1'b0, 3'b101});
    sb_check("post_reset_polarity");

    // Edge basic plus mid-period shadow write on ch1 (2 -> 7)
    setup(0, 9, 0, 3'b000, 9'd3, 9'd2, 9'd10);
    wr_at = 5; wr_ch_v = 2'd1; wr_val = 9'd7; d_new[1] = 9'd7; chg_per = 1;
    run("edge_midwrite", 30);

    // Write coincident with the boundary edge applies one period later
    setup(0, 9, 0, 3'b000, 9'd3, 9'd2, 9'd5);
    wr_at = 9; wr_ch_v = 2'd1; wr_val = 9'd7; d_new[1] = 9'd7; chg_per = 2;
    run("edge_bndwrite", 32);

    // Center mode: duty 2, duty 0 inverted, duty above top
    setup(1, 4, 0, 3'b010, 9'd2, 9'd0, 9'd5);
    run("center", 24);

    // Extremes with polarity inversion
    setup(0, 9, 0, 3'b011, 9'd0, 9'd10, 9'd3);
    run("extremes", 20);

    // Zero period: every tick is a boundary in both modes
    setup(0, 0, 0, 3'b000, 9'd1, 9'd0, 9'd1);
    run("per0_edge", 6);
    setup(1, 0, 1, 3'b100, 9'd1, 9'd0, 9'd0);
    run("per0_center", 8);

    // Prescaled edge mode; an out-of-range channel write must change nothing
    setup(0, 4, 3, 3'b000, 9'd1, 9'd3, 9'd0);
    wr_at = 7; wr_ch_v = 2'd3; wr_val = 9'd9;
    run("prescale", 45);

    // Asynchronous reset mid-period
    setup(0, 9, 0, 3'b101, 9'd3, 9'd3, 9'd3);
    run("pre_reset", 5);
    @(posedge clk);
    #2 reset_n = 1'b0;
    enable = 1'b0;
    #1 sb_q.push_back(4'b0000);
    sb_check("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sb_q.push_back({1'b0, 3'b101});
    sb_check("after_reset_disabled");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator: the parametrised successor of the single-channel PWM block. CH outputs share one prescaled period counter, with per-channel double-buffered duty registers, programmable period, edge- or center-aligned counting, per-channel output polarity and a period-boundary strobe. It sits between a register/control interface and motor, LED or timing pins. Duty and period updates are glitch-free: they take effect only at period boundaries.

## Interface
- CH, 4: number of PWM channels (1..16).
- N, 8: counter resolution in bits; duty is N+1 bits so that 100 % is reachable.
- PRESC_BITS, 15: prescaler width.
- clk, in, 1: single clock.
- reset_n, in, 1: asynchronous, active-low reset; all state cleared immediately.
- enable, in, 1: run when 1; when 0, counters are held and outputs are forced to the inactive level.
- mode, in, 1: 0 = edge-aligned (sawtooth), 1 = center-aligned (triangle).
- prescale, in, PRESC_BITS: a count tick every prescale+1 clk cycles.
- period, in, N: top count; sampled into the active period at a boundary.
- polarity, in, CH: per channel; 1 inverts the output.
- wr_en, in, 1: write strobe for a duty shadow register.
- wr_ch, in, clog2(CH) (min 1): channel index; writes with wr_ch >= CH are ignored.
- wr_duty, in, N+1: duty value written to shadow[wr_ch].
- pwm_out, out, CH: registered PWM outputs.
- period_tick, out, 1: one-clk pulse per period boundary.

## Operation
- **Prescaler**
  - psc counts 0..prescale; tick = (psc == prescale).
  - psc wraps to 0 on tick.
  - prescale = 0 gives a tick every clk.
- **Edge mode**
  - On tick, cnt increments.
  - When cnt == per_act, cnt goes to 0 (boundary).
  - Period length is (per_act+1) ticks.
- **Center mode**
  - dir = up: cnt increments. At cnt == per_act, cnt goes to per_act-1 and dir goes down.
  - dir = down: cnt decrements. At cnt == 1, cnt goes to 0 and dir goes up (boundary).
  - Period length is 2*per_act ticks.
- **per_act == 0**: cnt is held at 0 in both modes, and every tick is a boundary.
- **Shadowing**
  - wr_en writes shadow[wr_ch] in any cycle.
  - At a boundary, duty_act[i] <= shadow[i] for all channels, and per_act <= period.
- **enable = 0**
  - psc, cnt = 0; dir = up.
  - duty_act and per_act track shadow and period every cycle (immediate load).
- **Compare**, registered every clk:
  - pwm_out[i] <= (enable & (cnt < duty_act[i])) ^ polarity[i].
  - duty_act = 0 gives constant inactive; duty_act > per_act gives constant active.
  - Compare is unsigned, width N+1.
- **Simultaneous wr_en and boundary**: the active register takes the old shadow value; the new value applies from the following boundary.

## Timing
- Reset: psc, cnt, dir (up), all shadows, duty_act, per_act, pwm_out and period_tick are all 0.
  - pwm_out reflects polarity from the first clk after reset release.
- pwm_out lags cnt by one clk.
- period_tick is registered: high for exactly one clk, in the cycle after the boundary tick, coincident with the new cnt = 0.
- enable rising: counting starts on that clk edge; the first tick comes prescale+1 cycles later.
- enable falling: counters clear on the next edge; pwm_out goes inactive on the same edge.
- Changing mode mid-period is legal:
  - Switching to edge mode: dir is ignored, and cnt continues upward, wrapping at per_act.
  - Switching to center mode with cnt > per_act: dir is forced down.
- A prescale change takes effect on the next compare. If psc > prescale, psc wraps at its maximum.
- Reset asserted mid-period: outputs clear asynchronously, with no completion of the current period.

## Test plan
- Edge mode basic: N=8, prescale=0, period=9, ch0 duty=3 -> pwm_out[0] high 3 of every 10 clk; period_tick every 10 clk.
- Shadow timing: mid-period, write ch1 duty 2 -> 7 -> the old duty finishes the current period and 7 applies from the next cnt=0. A write coincident with a boundary -> applies one period later.
- Center mode: period=4, duty=2 -> cnt sequence 0,1,2,3,4,3,2,1; pwm high 3 of 8 clk, symmetric about cnt=4; period_tick every 8 clk.
- Extremes: duty 0 -> constant low; duty 10 with period 9 -> constant high; polarity=1 inverts both; period=0 -> period_tick every tick.
- Prescale: prescale=3, period=4 -> period of 20 clk; duty=1 gives 4 clk high. wr_ch=CH -> no shadow changes.
- Reset and enable: assert reset_n mid-period -> pwm_out=0 and period_tick=0 immediately, all registers 0. enable=0 -> outputs at polarity level, cnt held at 0.
